ctrl_conv_output_ml: RTL and testbench

Multi-lane, stride-aware successor to the convolution output controller. After the X and F memories are full, it issues groups of up to LANES convolution windows per pipeline advance into LANES parallel MAC pipelines of depth PLINE_STAGES. It tracks occupancy with a per-stage valid/mask/last shift register instead of fill/flush counters, so stalls and bubbles are exact. It drives the AXI-style output handshake and pulses `conv_done` when the last group has been consumed.

---
 rtl/conv_ctrl_pkg.sv | 23 ++
 rtl/pline_valid_tracker.sv | 48 ++++
 rtl/ctrl_conv_output_ml.sv | 162 ++++++++++++++++
 tb/tb_ctrl_conv_output_ml.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_ctrl_pkg.sv
// Shared types and helpers for the convolution output controller.
//   conv_state_e : controller states (IDLE, ISSUE, DRAIN)
//   trk_flags_t  : per-stage tracker flags; the lane mask is stored beside it
//                  because its width depends on the instantiating LANES value
//   norm_stride  : maps a raw stride of 0 to 1
package conv_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } conv_state_e;

    typedef struct packed {
        logic valid;
        logic last;
    } trk_flags_t;

    function automatic logic [1:0] norm_stride(input logic [1:0] s);
        return (s == 2'd0) ? 2'd1 : s;
    endfunction

endpackage

// File: rtl/pline_valid_tracker.sv
// Occupancy tracker that mirrors the MAC pipeline: one entry per stage,
// shifting by one on each enabled cycle. The last stage is the pipeline head.
//   clk, reset        : clock, asynchronous active-high reset
//   i_en              : pipeline advance enable
//   i_inj_valid/mask/last : entry written into stage 0 on advance
//   o_head_valid/mask/last: entry currently at the pipeline output
module pline_valid_tracker
    import conv_ctrl_pkg::*;
#(
    parameter int unsigned PLINE_STAGES = 5,
    parameter int unsigned LANES        = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_en,
    input  logic             i_inj_valid,
    input  logic [LANES-1:0] i_inj_mask,
    input  logic             i_inj_last,
    output logic             o_head_valid,
    output logic [LANES-1:0] o_head_mask,
    output logic             o_head_last
);

    trk_flags_t       r_flags [PLINE_STAGES];
    logic [LANES-1:0] r_mask  [PLINE_STAGES];

    // No enable means no movement, so a stalled head keeps its payload.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < PLINE_STAGES; i++) begin
                r_flags[i] <= '0;
                r_mask[i]  <= '0;
            end
        end else if (i_en) begin
            r_flags[0] <= '{valid: i_inj_valid, last: i_inj_last};
            r_mask[0]  <= i_inj_mask;
            for (int i = 1; i < PLINE_STAGES; i++) begin
                r_flags[i] <= r_flags[i-1];
                r_mask[i]  <= r_mask[i-1];
            end
        end
    end

    assign o_head_valid = r_flags[PLINE_STAGES-1].valid;
    assign o_head_last  = r_flags[PLINE_STAGES-1].last;
    assign o_head_mask  = r_mask[PLINE_STAGES-1];

endmodule

// File: rtl/ctrl_conv_output_ml.sv
// Multi-lane, stride-aware convolution output controller.
// Issues groups of up to LANES windows per pipeline advance, tracks them
// through the MAC pipeline and presents each group on a valid/ready output.
//   clk, reset       : clock, asynchronous active-high reset
//   conv_start       : memories full, convolution may begin (level)
//   stride           : window stride (0 means 1), sampled on start accept
//   m_ready_y        : downstream ready
//   load_xaddr_val   : base X address of the group being issued
//   lane_xaddr       : per-lane X address, zero for inactive lanes
//   en_pline_stages  : advance enable for all MAC pipeline registers
//   m_valid_y/m_lane_mask_y/m_last_y : output group handshake and payload
//   conv_done        : one-cycle pulse after the final group is consumed
module ctrl_conv_output_ml
    import conv_ctrl_pkg::*;
#(
    parameter int unsigned X_MEM_SIZE       = 8,
    parameter int unsigned F_MEM_SIZE       = 4,
    parameter int unsigned X_MEM_ADDR_WIDTH = 3,
    parameter int unsigned F_MEM_ADDR_WIDTH = 2,
    parameter int unsigned PLINE_STAGES     = 5,
    parameter int unsigned LANES            = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          conv_start,
    input  logic [1:0]                    stride,
    input  logic                          m_ready_y,
    output logic [X_MEM_ADDR_WIDTH-1:0]   load_xaddr_val,
    output logic [LANES*X_MEM_ADDR_WIDTH-1:0] lane_xaddr,
    output logic                          en_pline_stages,
    output logic                          m_valid_y,
    output logic [LANES-1:0]              m_lane_mask_y,
    output logic                          m_last_y,
    output logic                          conv_done
);

    // Two guard bits so base + LANES*S never wraps before truncation.
    localparam int unsigned SW   = X_MEM_ADDR_WIDTH + 2;
    localparam int unsigned SPAN = X_MEM_SIZE - F_MEM_SIZE;

    if (F_MEM_SIZE > X_MEM_SIZE) begin : g_bad_fsize
        $error("F_MEM_SIZE must not exceed X_MEM_SIZE");
    end
    if ((1 << F_MEM_ADDR_WIDTH) < F_MEM_SIZE) begin : g_bad_faddr
        $error("F_MEM_ADDR_WIDTH too narrow for F_MEM_SIZE");
    end
    if (PLINE_STAGES < 2) begin : g_bad_stages
        $error("PLINE_STAGES must be at least 2");
    end

    conv_state_e       r_state;
    logic [1:0]        r_stride;
    logic [SW-1:0]     r_base;
    logic [SW-1:0]     r_rem;
    logic              r_done;

    logic [1:0]        w_s;
    logic [SW-1:0]     w_n_out;
    logic [SW-1:0]     w_step;
    logic              w_en;
    logic              w_last_grp;
    logic              w_hs_last;
    logic [LANES-1:0]  w_mask;
    logic [LANES*X_MEM_ADDR_WIDTH-1:0] w_lane_xaddr;
    logic              w_head_valid;
    logic [LANES-1:0]  w_head_mask;
    logic              w_head_last;

    assign w_s        = norm_stride(stride);
    assign w_step     = SW'(LANES) * SW'(r_stride);
    assign w_en       = (r_state != IDLE) && (!w_head_valid || m_ready_y);
    assign w_last_grp = (r_rem <= SW'(LANES));
    assign w_hs_last  = w_head_valid && m_ready_y && w_head_last;

    // Output count per stride; the divisors are constants so no divider is built.
    always_comb begin
        unique case (w_s)
            2'd2:    w_n_out = SW'(SPAN / 2 + 1);
            2'd3:    w_n_out = SW'(SPAN / 3 + 1);
            default: w_n_out = SW'(SPAN + 1);
        endcase
    end

    always_comb begin
        w_mask       = '0;
        w_lane_xaddr = '0;
        for (int k = 0; k < LANES; k++) begin
            w_mask[k] = (SW'(k) < r_rem);
            if (w_mask[k]) begin
                w_lane_xaddr[k*X_MEM_ADDR_WIDTH +: X_MEM_ADDR_WIDTH] =
                    X_MEM_ADDR_WIDTH'(r_base + SW'(k) * SW'(r_stride));
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_stride <= 2'd1;
            r_base   <= '0;
            r_rem    <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    // The done-pulse cycle blocks acceptance, so a held start
                    // restarts one cycle later.
                    if (conv_start && !r_done) begin
                        r_stride <= w_s;
                        r_rem    <= w_n_out;
                        r_base   <= '0;
                        r_state  <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (w_en) begin
                        if (w_last_grp) begin
                            r_state <= DRAIN;
                        end else begin
                            r_base <= r_base + w_step;
                            r_rem  <= r_rem - SW'(LANES);
                        end
                    end
                end
                DRAIN: begin
                    if (w_hs_last) begin
                        r_done  <= 1'b1;
                        r_base  <= '0;
                        r_rem   <= '0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    pline_valid_tracker #(
        .PLINE_STAGES (PLINE_STAGES),
        .LANES        (LANES)
    ) u_tracker (
        .clk          (clk),
        .reset        (reset),
        .i_en         (w_en),
        .i_inj_valid  (r_state == ISSUE),
        .i_inj_mask   ((r_state == ISSUE) ? w_mask : '0),
        .i_inj_last   ((r_state == ISSUE) && w_last_grp),
        .o_head_valid (w_head_valid),
        .o_head_mask  (w_head_mask),
        .o_head_last  (w_head_last)
    );

    assign load_xaddr_val  = X_MEM_ADDR_WIDTH'(r_base);
    assign lane_xaddr      = w_lane_xaddr;
    assign en_pline_stages = w_en;
    assign m_valid_y       = w_head_valid;
    assign m_lane_mask_y   = w_head_mask;
    assign m_last_y        = w_head_last;
    assign conv_done       = r_done;

endmodule

// File: tb/tb_ctrl_conv_output_ml.sv
module tb_ctrl_conv_output_ml;

    localparam int XS = 8;
    localparam int FS = 4;
    localparam int AW = 3;
    localparam int P  = 5;
    localparam int L  = 2;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            conv_start = 1'b0;
    logic [1:0]      stride = 2'd1;
    logic            m_ready_y = 1'b1;
    logic [AW-1:0]   load_xaddr_val;
    logic [L*AW-1:0] lane_xaddr;
    logic            en_pline_stages;
    logic            m_valid_y;
    logic [L-1:0]    m_lane_mask_y;
    logic            m_last_y;
    logic            conv_done;

    ctrl_conv_output_ml #(
        .X_MEM_SIZE       (XS),
        .F_MEM_SIZE       (FS),
        .X_MEM_ADDR_WIDTH (AW),
        .F_MEM_ADDR_WIDTH (2),
        .PLINE_STAGES     (P),
        .LANES            (L)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .conv_start      (conv_start),
        .stride          (stride),
        .m_ready_y       (m_ready_y),
        .load_xaddr_val  (load_xaddr_val),
        .lane_xaddr      (lane_xaddr),
        .en_pline_stages (en_pline_stages),
        .m_valid_y       (m_valid_y),
        .m_lane_mask_y   (m_lane_mask_y),
        .m_last_y        (m_last_y),
        .conv_done       (conv_done)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    bit m_active = 0;
    int m_S = 1, m_nout = 0, m_groups = 0;
    int issued = 0, outs = 0, ens = 0, cyc = 0, abs_cyc = 0;
    int inj_en [16];
    bit done_exp = 0;
    bit hold_v = 0;
    logic [L-1:0] hold_mask;
    logic hold_last;
    int done_count = 0, done_cyc = -1, last_done_abs = -100, gap_last = -1;
    int log_base [16], log_lanes [16], log_mask [16], log_last [16], log_hs_cyc [16];

    function automatic void exp_group(input int g, output logic [AW-1:0] base,
                                      output logic [L*AW-1:0] lanes,
                                      output logic [L-1:0] mask, output logic last);
        int b, rem;
        b = g * L * m_S;
        rem = m_nout - g * L;
        base = AW'(b);
        lanes = '0;
        mask = '0;
        for (int k = 0; k < L; k++) begin
            if (k < rem) begin
                mask[k] = 1'b1;
                lanes[k*AW +: AW] = AW'(b + k * m_S);
            end
        end
        last = (rem <= L);
    endfunction

    always @(negedge clk) begin
        logic [AW-1:0] eb;
        logic [L*AW-1:0] el;
        logic [L-1:0] em;
        logic elast, cur_done, exp_v, hs_last;
        abs_cyc++;
        if (reset) begin
            chk("rst_load_xaddr", load_xaddr_val, 0);
            chk("rst_lane_xaddr", lane_xaddr, 0);
            chk("rst_en", en_pline_stages, 0);
            chk("rst_valid", m_valid_y, 0);
            chk("rst_mask", m_lane_mask_y, 0);
            chk("rst_last", m_last_y, 0);
            chk("rst_done", conv_done, 0);
            m_active = 0; issued = 0; outs = 0; ens = 0;
            done_exp = 0; hold_v = 0;
        end else begin
            cur_done = done_exp;
            hs_last = 0;
            chk("conv_done", conv_done, cur_done);
            if (conv_done) begin
                done_count++; done_cyc = cyc; last_done_abs = abs_cyc;
            end
            chk("en_pline", en_pline_stages, m_active && (!m_valid_y || m_ready_y));
            exp_v = m_active && (outs < issued) && (ens >= inj_en[outs] + P);
            chk("m_valid", m_valid_y, exp_v);
            if (hold_v) begin
                chk("stall_mask", m_lane_mask_y, hold_mask);
                chk("stall_last", m_last_y, hold_last);
            end
            if (!m_active) chk("idle_base", load_xaddr_val, 0);
            if (m_valid_y && m_ready_y && outs < 16) begin
                exp_group(outs, eb, el, em, elast);
                chk("out_mask", m_lane_mask_y, em);
                chk("out_last", m_last_y, elast);
                log_mask[outs] = m_lane_mask_y;
                log_last[outs] = m_last_y;
                log_hs_cyc[outs] = cyc;
                hs_last = (outs == m_groups - 1);
                outs++;
            end
            if (m_active && en_pline_stages && issued < m_groups) begin
                exp_group(issued, eb, el, em, elast);
                chk("issue_base", load_xaddr_val, eb);
                chk("issue_lanes", lane_xaddr, el);
                log_base[issued] = load_xaddr_val;
                log_lanes[issued] = lane_xaddr;
                inj_en[issued] = ens;
                issued++;
            end
            if (en_pline_stages) ens++;
            hold_v = m_valid_y && !m_ready_y;
            hold_mask = m_lane_mask_y;
            hold_last = m_last_y;
            done_exp = hs_last;
            if (hs_last) m_active = 0;
            if (!m_active && !hs_last && conv_start && !cur_done) begin
                m_S = (stride == 2'd0) ? 1 : int'(stride);
                m_nout = (XS - FS) / m_S + 1;
                m_groups = (m_nout + L - 1) / L;
                issued = 0; outs = 0; ens = 0;
                m_active = 1;
                gap_last = abs_cyc - last_done_abs;
                cyc = 0;
            end
            cyc++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic run(input logic [1:0] s, input bit toggle, input int ndone);
        int seen = 0;
        int n = 0;
        stride = s;
        conv_start = 1'b1;
        m_ready_y = 1'b1;
        while (seen < ndone && n < 400) begin
            @(posedge clk); #1;
            n++;
            if (ndone == 1) begin
                conv_start = 1'b0;
                stride = ~s;
            end
            if (conv_done) begin
                seen++;
                if (seen == ndone) conv_start = 1'b0;
            end
            m_ready_y = toggle ? ((n % 4 == 0) || (n % 4 == 3)) : 1'b1;
        end
        chk("run_done_seen", seen, ndone);
        conv_start = 1'b0;
        m_ready_y = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_s1_literals(input string tag);
        chk({tag, "_base0"}, log_base[0], 0);
        chk({tag, "_base1"}, log_base[1], 2);
        chk({tag, "_base2"}, log_base[2], 4);
        chk({tag, "_mask0"}, log_mask[0], 3);
        chk({tag, "_mask1"}, log_mask[1], 3);
        chk({tag, "_mask2"}, log_mask[2], 1);
        chk({tag, "_last1"}, log_last[1], 0);
        chk({tag, "_last2"}, log_last[2], 1);
        chk({tag, "_first_valid_cyc"}, log_hs_cyc[0], 6);
        chk({tag, "_done_cyc"}, done_cyc, 9);
        chk({tag, "_outs"}, outs, 3);
    endtask

    initial begin
        int dc;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // S=1, ready high
        run(2'd1, 1'b0, 1);
        check_s1_literals("s1");

        // S=2: lanes {0,2} then {4,0}
        run(2'd2, 1'b0, 1);
        chk("s2_lanes0", log_lanes[0], (2 << AW) | 0);
        chk("s2_lanes1", log_lanes[1], (0 << AW) | 4);
        chk("s2_mask0", log_mask[0], 3);
        chk("s2_mask1", log_mask[1], 1);
        chk("s2_outs", outs, 2);

        // S=3: single group {0,3}
        run(2'd3, 1'b0, 1);
        chk("s3_lanes0", log_lanes[0], (3 << AW) | 0);
        chk("s3_mask0", log_mask[0], 3);
        chk("s3_last0", log_last[0], 1);
        chk("s3_outs", outs, 1);

        // S=0 behaves as S=1
        run(2'd0, 1'b0, 1);
        check_s1_literals("s0");

        // Back-pressure toggling
        dc = done_count;
        run(2'd1, 1'b1, 1);
        chk("bp_outs", outs, 3);
        chk("bp_dones", done_count - dc, 1);

        // Held start: restart one cycle after the done pulse
        run(2'd1, 1'b0, 2);
        chk("held_gap", gap_last, 1);
        check_s1_literals("held");

        // Reset in the cycle after the second issue
        dc = done_count;
        stride = 2'd1;
        conv_start = 1'b1;
        @(posedge clk); #1;
        conv_start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_rst_issued", issued, 2);
        #1 reset = 1'b1;
        #1;
        chk("async_rst_base", load_xaddr_val, 0);
        chk("async_rst_lanes", lane_xaddr, 0);
        chk("async_rst_en", en_pline_stages, 0);
        chk("async_rst_valid", m_valid_y, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("rst_no_done", done_count, dc);
        run(2'd1, 1'b0, 1);
        check_s1_literals("post_rst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
